spi_req_arbiter: RTL and testbench



---
 rtl/spi_arb_pkg.sv | 39 +++
 rtl/rr_arbiter_fixed_ptr.sv | 32 +++
 rtl/spi_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_spi_req_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and id-field helpers for the SPI request arbiter
package spi_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Helpers work on the widest supported message; callers size-cast in and out.
    localparam int MAX_DBITS = 64;
    localparam int MAX_IDW   = 3;

    function automatic int id_width(input int nreq);
        return $clog2(nreq);
    endfunction

    function automatic int payload_width(input int dbits, input int idw);
        return dbits - idw;
    endfunction

    function automatic logic [MAX_IDW-1:0] id_extract(
        input logic [MAX_DBITS-1:0] msg,
        input int unsigned          dbits,
        input int unsigned          idw
    );
        logic [MAX_DBITS-1:0] w_mask;
        w_mask = (MAX_DBITS'(1) << idw) - MAX_DBITS'(1);
        return MAX_IDW'((msg >> (dbits - idw)) & w_mask);
    endfunction

    function automatic logic [MAX_DBITS-1:0] id_insert(
        input logic [MAX_IDW-1:0]   id,
        input logic [MAX_DBITS-1:0] payload,
        input int unsigned          pbits
    );
        return (MAX_DBITS'(id) << pbits) | payload;
    endfunction

endpackage

// File: rtl/rr_arbiter_fixed_ptr.sv
// rtl/rr_arbiter_fixed_ptr.sv - combinational round-robin pick starting at an external pointer
module rr_arbiter_fixed_ptr #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    always_comb begin
        logic           w_found;
        logic [IDW-1:0] w_cand;
        w_found = 1'b0;
        w_cand  = '0;
        o_idx   = '0;
        o_gnt   = '0;
        // NREQ is a power of two, so IDW-bit addition wraps modulo NREQ.
        for (int i = 0; i < NREQ; i++) begin
            w_cand = i_ptr + IDW'(i);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (w_found) begin
            o_gnt = NREQ'(1) << o_idx;
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - shares the SPI adapter message stream among NREQ requesters
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DBITS   = 32,
    parameter int IDW     = id_width(NREQ),
    parameter int PBITS   = payload_width(DBITS, IDW),
    parameter int MAX_OUT = 5,
    parameter int CW      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_val,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ*PBITS-1:0] req_msg,
    output logic                  ad_send_val,
    input  logic                  ad_send_rdy,
    output logic [DBITS-1:0]      ad_send_msg,
    input  logic                  ad_recv_val,
    output logic                  ad_recv_rdy,
    input  logic [DBITS-1:0]      ad_recv_msg,
    output logic [NREQ-1:0]       resp_val,
    input  logic [NREQ-1:0]       resp_rdy,
    output logic [NREQ*PBITS-1:0] resp_msg,
    output logic [CW-1:0]         outstanding,
    output logic                  err
);

    localparam int NID = 2**IDW;
    localparam logic [NID-1:0] ID_OK = NID'((64'd1 << NREQ) - 64'd1);

    arb_state_t      r_state, w_state_nxt;
    logic [IDW-1:0]  r_ptr, w_ptr_nxt;
    logic [IDW-1:0]  r_gnt, w_gnt_nxt;
    logic [CW-1:0]   r_out;
    logic            r_err;

    logic [NREQ-1:0] w_arb_gnt;
    logic [IDW-1:0]  w_arb_idx;
    logic            w_send_val;
    logic [IDW-1:0]  w_send_idx;
    logic [NREQ-1:0] w_req_rdy;
    logic            w_hold_drop;
    logic [PBITS-1:0] w_payload;
    logic [IDW-1:0]  w_rid;
    logic [NREQ-1:0] w_resp_val;
    logic            w_recv_rdy;
    logic            w_send_fire, w_recv_fire, w_spurious, w_bad_id;

    rr_arbiter_fixed_ptr #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .i_req (req_val),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_send_val  = 1'b0;
        w_send_idx  = r_gnt;
        w_req_rdy   = '0;
        w_hold_drop = 1'b0;
        case (r_state)
            IDLE: begin
                // Gate on the registered count: a same-cycle response does not free a slot yet.
                if (r_out != CW'(MAX_OUT) && |w_arb_gnt) begin
                    w_send_val = 1'b1;
                    w_send_idx = w_arb_idx;
                    w_req_rdy  = w_arb_gnt & {NREQ{ad_send_rdy}};
                    if (ad_send_rdy) begin
                        w_ptr_nxt = w_arb_idx + IDW'(1);
                    end else begin
                        w_gnt_nxt   = w_arb_idx;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req_val[r_gnt]) begin
                    w_send_val         = 1'b1;
                    w_req_rdy[r_gnt]   = ad_send_rdy;
                    if (ad_send_rdy) begin
                        w_ptr_nxt   = r_gnt + IDW'(1);
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_hold_drop = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_payload   = req_msg[w_send_idx*PBITS +: PBITS];
    assign ad_send_msg = DBITS'(id_insert(MAX_IDW'(w_send_idx), MAX_DBITS'(w_payload), PBITS));
    assign ad_send_val = w_send_val & ~reset;
    assign req_rdy     = w_req_rdy & {NREQ{~reset}};

    assign w_rid = IDW'(id_extract(MAX_DBITS'(ad_recv_msg), DBITS, IDW));

    always_comb begin
        w_resp_val = '0;
        w_recv_rdy = 1'b1;
        if (ID_OK[w_rid]) begin
            w_resp_val[w_rid] = ad_recv_val;
            w_recv_rdy        = resp_rdy[w_rid];
        end
    end

    assign resp_val    = w_resp_val & {NREQ{~reset}};
    assign ad_recv_rdy = w_recv_rdy & ~reset;
    assign resp_msg    = {NREQ{ad_recv_msg[PBITS-1:0]}};

    assign w_send_fire = ad_send_val && ad_send_rdy;
    assign w_recv_fire = ad_recv_val && ad_recv_rdy;
    assign w_spurious  = w_recv_fire && !w_send_fire && (r_out == '0);
    assign w_bad_id    = ad_recv_val && !ID_OK[w_rid];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            if (w_send_fire && !w_recv_fire) begin
                r_out <= r_out + CW'(1);
            end else if (!w_send_fire && w_recv_fire && r_out != '0) begin
                r_out <= r_out - CW'(1);
            end
            if (w_hold_drop || w_spurious || w_bad_id) begin
                r_err <= 1'b1;
            end
        end
    end

    assign outstanding = r_out;
    assign err         = r_err;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed vector bench for spi_req_arbiter
module tb_spi_req_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_val;
    logic [3:0]   req_rdy;
    logic [119:0] req_msg;
    logic         ad_send_val;
    logic         ad_send_rdy;
    logic [31:0]  ad_send_msg;
    logic         ad_recv_val;
    logic         ad_recv_rdy;
    logic [31:0]  ad_recv_msg;
    logic [3:0]   resp_val;
    logic [3:0]   resp_rdy;
    logic [119:0] resp_msg;
    logic [2:0]   outstanding;
    logic         err;

    spi_req_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_msg     (req_msg),
        .ad_send_val (ad_send_val),
        .ad_send_rdy (ad_send_rdy),
        .ad_send_msg (ad_send_msg),
        .ad_recv_val (ad_recv_val),
        .ad_recv_rdy (ad_recv_rdy),
        .ad_recv_msg (ad_recv_msg),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_msg    (resp_msg),
        .outstanding (outstanding),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic       srdy;
        logic       rval;
        logic [1:0] rid;
        logic [3:0] prdy;
        logic [3:0] e_rrdy;
        logic       e_sval;
        logic [1:0] e_sid;
        logic       e_arr;
        logic [3:0] e_resp;
        logic [2:0] e_out;
        logic       e_err;
    } vec_t;

    localparam logic [29:0] RPAY = 30'h0155_0000;
    logic [29:0] pay [4];
    vec_t vecs [$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic vec_t mk(input logic [3:0] rv, input logic srdy, input logic rval,
                                input logic [1:0] rid, input logic [3:0] prdy,
                                input logic [3:0] e_rrdy, input logic e_sval, input logic [1:0] e_sid,
                                input logic e_arr, input logic [3:0] e_resp, input logic [2:0] e_out,
                                input logic e_err);
        vec_t v;
        v.rv = rv; v.srdy = srdy; v.rval = rval; v.rid = rid; v.prdy = prdy;
        v.e_rrdy = e_rrdy; v.e_sval = e_sval; v.e_sid = e_sid; v.e_arr = e_arr;
        v.e_resp = e_resp; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [31:0] exp_msg(input logic [1:0] id);
        return {id, pay[id]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives inputs just after the falling edge and settles before sampling.
    task automatic drive(input logic rst, input logic [3:0] rv, input logic srdy,
                         input logic rval, input logic [1:0] rid, input logic [3:0] prdy);
        @(negedge clk);
        reset       = rst;
        req_val     = rv;
        ad_send_rdy = srdy;
        ad_recv_val = rval;
        ad_recv_msg = {rid, RPAY | {28'd0, rid}};
        resp_rdy    = prdy;
        #2;
    endtask

    initial begin
        pay[0] = 30'h0000_0AAA;
        pay[1] = 30'h0000_1234;
        pay[2] = 30'h0000_2222;
        pay[3] = 30'h0000_3333;
        req_msg = {pay[3], pay[2], pay[1], pay[0]};
        reset = 1'b1; req_val = '0; ad_send_rdy = 1'b0; ad_recv_val = 1'b0;
        ad_recv_msg = '0; resp_rdy = '0;

        //                rv     srdy  rval  rid    prdy      rrdy    sval  sid    arr   resp    out   err
        vecs.push_back(mk(4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0000, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 3'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd1, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b1, 4'b0010, 3'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd2, 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b1, 4'b0100, 3'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd3, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b1000, 3'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd0, 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0001, 3'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000, 3'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd3, 4'b0111, 4'b1000, 1'b1, 2'd3, 1'b0, 4'b1000, 3'd2, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 4'b0111, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 3'd3, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1000, 3'd3, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 3'd2, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 3'd2, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 3'd2, 1'b0));
        vecs.push_back(mk(4'b0101, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 3'd2, 1'b0));
        vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000, 3'd2, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0000, 3'd3, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 4'b0000, 3'd4, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 3'd5, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0010, 3'd5, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 4'b0000, 3'd4, 1'b0));
        for (int k = 5; k >= 1; k--) begin
            vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0001, 3'(k), 1'b0));
        end
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0001, 3'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 3'd0, 1'b1));

        // Outputs held low while reset is high, even with every input asserted.
        drive(1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b1111);
        chk("rst send_val", 128'(ad_send_val), 128'(0));
        chk("rst req_rdy", 128'(req_rdy), 128'(0));
        chk("rst recv_rdy", 128'(ad_recv_rdy), 128'(0));
        chk("rst resp_val", 128'(resp_val), 128'(0));
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        chk("rst outstanding", 128'(outstanding), 128'(0));
        chk("rst err", 128'(err), 128'(0));

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].rv, vecs[i].srdy, vecs[i].rval, vecs[i].rid, vecs[i].prdy);
            chk($sformatf("v%0d req_rdy", i), 128'(req_rdy), 128'(vecs[i].e_rrdy));
            chk($sformatf("v%0d send_val", i), 128'(ad_send_val), 128'(vecs[i].e_sval));
            if (vecs[i].e_sval) begin
                chk($sformatf("v%0d send_msg", i), 128'(ad_send_msg), 128'(exp_msg(vecs[i].e_sid)));
            end
            chk($sformatf("v%0d recv_rdy", i), 128'(ad_recv_rdy), 128'(vecs[i].e_arr));
            chk($sformatf("v%0d resp_val", i), 128'(resp_val), 128'(vecs[i].e_resp));
            if (vecs[i].rval) begin
                chk($sformatf("v%0d resp_msg", i), 128'(resp_msg),
                    128'({4{RPAY | {28'd0, vecs[i].rid}}}));
            end
            chk($sformatf("v%0d outstanding", i), 128'(outstanding), 128'(vecs[i].e_out));
            chk($sformatf("v%0d err", i), 128'(err), 128'(vecs[i].e_err));
        end

        // Reset clears the sticky error.
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        chk("reclear err", 128'(err), 128'(0));
        chk("reclear outstanding", 128'(outstanding), 128'(0));

        // Requester 3 drops val while held.
        drive(1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000);
        chk("hold3 send_val", 128'(ad_send_val), 128'(1));
        chk("hold3 send_msg", 128'(ad_send_msg), 128'(exp_msg(2'd3)));
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        chk("drop send_val", 128'(ad_send_val), 128'(0));
        chk("drop err pre", 128'(err), 128'(0));
        drive(1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000);
        chk("drop err", 128'(err), 128'(1));
        chk("drop outstanding", 128'(outstanding), 128'(0));
        chk("after drop req_rdy", 128'(req_rdy), 128'(4'b0010));
        chk("after drop send_msg", 128'(ad_send_msg), 128'(exp_msg(2'd1)));

        // Reset arrives while requester 2 is held.
        drive(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000);
        chk("hold2 send_msg", 128'(ad_send_msg), 128'(exp_msg(2'd2)));
        chk("hold2 outstanding", 128'(outstanding), 128'(1));
        drive(1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b1111);
        chk("midhold send_val", 128'(ad_send_val), 128'(0));
        chk("midhold req_rdy", 128'(req_rdy), 128'(0));
        chk("midhold recv_rdy", 128'(ad_recv_rdy), 128'(0));
        chk("midhold resp_val", 128'(resp_val), 128'(0));
        drive(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000);
        chk("post rst outstanding", 128'(outstanding), 128'(0));
        chk("post rst err", 128'(err), 128'(0));
        chk("post rst send_val", 128'(ad_send_val), 128'(1));
        chk("post rst send_msg", 128'(ad_send_msg), 128'(exp_msg(2'd0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
